// File: rtl/iob2axi_wr_split_if.sv
// Native write stream plus AXI4 write channels (AW/W/B) for iob2axi_wr_split.
// master = the bridge side, slave = the stream source / AXI target side.
interface iob2axi_wr_split_if #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int AXI_ID_W  = 1,
    parameter int AXI_LEN_W = 8
);
    logic                   s_valid;
    logic [DATA_W-1:0]      s_wdata;
    logic [DATA_W/8-1:0]    s_wstrb;
    logic                   s_ready;

    logic [AXI_ID_W-1:0]    m_axi_awid;
    logic [ADDR_W-1:0]      m_axi_awaddr;
    logic [AXI_LEN_W-1:0]   m_axi_awlen;
    logic [2:0]             m_axi_awsize;
    logic [1:0]             m_axi_awburst;
    logic                   m_axi_awlock;
    logic [3:0]             m_axi_awcache;
    logic [2:0]             m_axi_awprot;
    logic [3:0]             m_axi_awqos;
    logic                   m_axi_awvalid;
    logic                   m_axi_awready;

    logic [DATA_W-1:0]      m_axi_wdata;
    logic [DATA_W/8-1:0]    m_axi_wstrb;
    logic                   m_axi_wlast;
    logic                   m_axi_wvalid;
    logic                   m_axi_wready;

    logic [AXI_ID_W-1:0]    m_axi_bid;
    logic [1:0]             m_axi_bresp;
    logic                   m_axi_bvalid;
    logic                   m_axi_bready;

    modport master (
        input  s_valid, s_wdata, s_wstrb,
        output s_ready,
        output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
        output m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
        output m_axi_bready
    );

    modport slave (
        output s_valid, s_wdata, s_wstrb,
        input  s_ready,
        input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
        input  m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bid, m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready
    );
endinterface

// File: rtl/iob2axi_wr_split.sv
// Native-to-AXI4 write bridge: splits one long transfer into INCR bursts (<= MAX_BURST, no 4 KB crossing).
// Define IOB2AXI_WR_ABORT_EN to end a transfer on the first error response.
module iob2axi_wr_split #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int AXI_ID_W  = 1,
    parameter int AXI_LEN_W = 8,
    parameter int MAX_BURST = 256,
    parameter int XFER_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [XFER_W-1:0]   length,
    output logic                busy,
    output logic                done,
    output logic                error,
    iob2axi_wr_split_if.master  bus
);
    localparam int SIZE_LOG2 = $clog2(DATA_W / 8);
    localparam int CNT_W     = AXI_LEN_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cur_addr;
    logic [XFER_W-1:0]   r_remain;
    logic [CNT_W-1:0]    r_blen;
    logic [CNT_W-1:0]    r_beat;
    logic                r_awvalid;
    logic                r_bready;
    logic                r_busy;
    logic                r_done;
    logic                r_error;

    logic [12:0]         w_to4k;
    logic [31:0]         w_rem_ext;
    logic [31:0]         w_to4k_ext;
    logic [31:0]         w_min_rb;
    logic [CNT_W-1:0]    w_blen;
    logic                w_w_hs;
    logic                w_last_beat;
    logic [XFER_W-1:0]   w_remain_after;
    logic [ADDR_W-1:0]   w_addr_step;
    logic                w_abort;
    logic                w_unused;

    // Words left before the next 4 KB page boundary.
    assign w_to4k     = (13'd4096 - {1'b0, r_cur_addr[11:0]}) >> SIZE_LOG2;
    assign w_rem_ext  = 32'(r_remain);
    assign w_to4k_ext = 32'(w_to4k);
    assign w_min_rb   = (w_rem_ext < 32'(MAX_BURST)) ? w_rem_ext : 32'(MAX_BURST);
    assign w_blen     = CNT_W'((w_min_rb < w_to4k_ext) ? w_min_rb : w_to4k_ext);

    assign w_w_hs         = (r_state == S_DATA) && bus.s_valid && bus.m_axi_wready;
    assign w_last_beat    = (r_beat == r_blen - CNT_W'(1));
    assign w_remain_after = r_remain - XFER_W'(r_blen);
    assign w_addr_step    = ADDR_W'(r_blen) << SIZE_LOG2;

`ifdef IOB2AXI_WR_ABORT_EN
    assign w_abort = bus.m_axi_bresp[1];
`else
    assign w_abort = 1'b0;
`endif

    assign w_unused = ^{bus.m_axi_bid, bus.m_axi_bresp[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cur_addr <= '0;
            r_remain   <= '0;
            r_blen     <= '0;
            r_beat     <= '0;
            r_awvalid  <= 1'b0;
            r_bready   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            r_cur_addr <= addr;
                            r_remain   <= length;
                            r_error    <= 1'b0;
                            r_busy     <= 1'b1;
                            r_state    <= S_ADDR;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_ADDR: begin
                    // First ADDR cycle registers the burst length; AW is raised once it is stable.
                    if (!r_awvalid) begin
                        r_blen    <= w_blen;
                        r_awvalid <= 1'b1;
                    end else if (bus.m_axi_awready) begin
                        r_awvalid <= 1'b0;
                        r_beat    <= '0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_w_hs) begin
                        r_beat <= r_beat + CNT_W'(1);
                        if (w_last_beat) begin
                            r_bready <= 1'b1;
                            r_state  <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (bus.m_axi_bvalid) begin
                        r_bready   <= 1'b0;
                        r_error    <= r_error | bus.m_axi_bresp[1];
                        r_remain   <= w_remain_after;
                        r_cur_addr <= r_cur_addr + w_addr_step;
                        if ((w_remain_after == '0) || w_abort) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_ADDR;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign error = r_error;

    assign bus.m_axi_awid    = '0;
    assign bus.m_axi_awaddr  = r_cur_addr;
    assign bus.m_axi_awlen   = AXI_LEN_W'(r_blen - CNT_W'(1));
    assign bus.m_axi_awsize  = 3'(SIZE_LOG2);
    assign bus.m_axi_awburst = 2'b01;
    assign bus.m_axi_awlock  = 1'b0;
    assign bus.m_axi_awcache = 4'd2;
    assign bus.m_axi_awprot  = 3'd2;
    assign bus.m_axi_awqos   = 4'd0;
    assign bus.m_axi_awvalid = r_awvalid;

    // The W channel is a straight pass-through of the native stream while a burst is open.
    assign bus.m_axi_wdata  = bus.s_wdata;
    assign bus.m_axi_wstrb  = bus.s_wstrb;
    assign bus.m_axi_wvalid = (r_state == S_DATA) && bus.s_valid;
    assign bus.m_axi_wlast  = (r_state == S_DATA) && w_last_beat;
    assign bus.s_ready      = (r_state == S_DATA) && bus.m_axi_wready;
    assign bus.m_axi_bready = r_bready;
endmodule

// File: tb/tb_iob2axi_wr_split.sv
// Directed self-checking bench for iob2axi_wr_split (DATA_W=32, MAX_BURST=256).
module tb_iob2axi_wr_split;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int AXI_ID_W  = 1;
    localparam int AXI_LEN_W = 8;
    localparam int MAX_BURST = 256;
    localparam int XFER_W    = 16;
`ifdef IOB2AXI_WR_ABORT_EN
    localparam int ERR_NB = 1;
`else
    localparam int ERR_NB = 2;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [ADDR_W-1:0]   addr = '0;
    logic [XFER_W-1:0]   length = '0;
    logic                busy;
    logic                done;
    logic                error;
    int                  n_pass = 0;
    int                  n_fail = 0;
    int                  n_total = 0;

    iob2axi_wr_split_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .AXI_ID_W(AXI_ID_W),
                          .AXI_LEN_W(AXI_LEN_W)) bus ();

    iob2axi_wr_split #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .AXI_ID_W(AXI_ID_W),
                       .AXI_LEN_W(AXI_LEN_W), .MAX_BURST(MAX_BURST), .XFER_W(XFER_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .addr   (addr),
        .length (length),
        .busy   (busy),
        .done   (done),
        .error  (error),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.s_valid       = 1'b0;
        bus.s_wdata       = '0;
        bus.s_wstrb       = '0;
        bus.m_axi_awready = 1'b0;
        bus.m_axi_wready  = 1'b0;
        bus.m_axi_bid     = '0;
        bus.m_axi_bresp   = 2'b00;
        bus.m_axi_bvalid  = 1'b0;
    endtask

    // One transfer of n words; up to two expected bursts (address, beats); bresp of burst 0 is br0.
    task automatic run_xfer(input string tag, input logic [31:0] a, input logic [15:0] n,
                            input int nb, input logic [31:0] ea0, input int el0,
                            input logic [31:0] ea1, input int el1, input logic [1:0] br0,
                            input bit tog, input bit gap, input bit exp_err);
        int burst = 0;
        int bbeat = 0;
        int sent = 0;
        int cyc = 0;
        int awwait = 0;
        int bwait = 0;
        int exp_len;
        bit in_data = 0;
        bit in_resp = 0;
        bit pend = 0;
        bit aw_pend = 0;
        bit finished = 0;
        logic [31:0] exp_aa;
        chk({tag, ":busy_before"}, busy, 0);
        start = 1'b1; addr = a; length = n;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, ":busy_after_start"}, busy, 1);
        chk({tag, ":error_cleared"}, error, 0);
        while (!finished) begin
            exp_aa  = (burst == 0) ? ea0 : ea1;
            exp_len = (burst == 0) ? el0 : el1;
            if (pend) begin
                chk({tag, ":done_pulse"}, done, 1);
                chk({tag, ":busy_end"}, busy, 0);
                chk({tag, ":error_end"}, error, exp_err);
                finished = 1;
            end else if (cyc >= 3000) begin
                chk({tag, ":timeout"}, pend, 1);
                finished = 1;
            end else begin
                chk({tag, ":done_low"}, done, 0);
                bus.s_valid       = (sent < n) && !(gap && (cyc % 3 == 1));
                bus.s_wdata       = 32'hA500_0000 + 32'(sent);
                bus.s_wstrb       = 4'(sent) | 4'b0001;
                bus.m_axi_wready  = !tog || (cyc % 2 == 0);
                bus.m_axi_awready = (awwait >= 2);
                bus.m_axi_bvalid  = in_resp && (bwait >= 1);
                bus.m_axi_bresp   = (burst == 0) ? br0 : 2'b00;
                #1;
                if (in_data || in_resp) chk({tag, ":aw_quiet"}, bus.m_axi_awvalid, 0);
                chk({tag, ":bready"}, bus.m_axi_bready, in_resp);
                if (in_resp) begin
                    if (bus.m_axi_bvalid) begin
                        in_resp = 0;
                        burst++;
                        if (burst == nb) pend = 1;
                    end else begin
                        bwait++;
                    end
                end
                if (in_data) begin
                    chk({tag, ":s_ready_eq_wready"}, bus.s_ready, bus.m_axi_wready);
                    chk({tag, ":wvalid_eq_svalid"}, bus.m_axi_wvalid, bus.s_valid);
                    if (bus.m_axi_wvalid && bus.m_axi_wready) begin
                        chk({tag, ":wdata"}, bus.m_axi_wdata, 32'hA500_0000 + 32'(sent));
                        chk({tag, ":wstrb"}, bus.m_axi_wstrb, 4'(sent) | 4'b0001);
                        chk({tag, ":wlast"}, bus.m_axi_wlast, bbeat == exp_len - 1);
                        sent++;
                        bbeat++;
                        if (bbeat == exp_len) begin
                            in_data = 0;
                            in_resp = 1;
                            bwait = 0;
                        end
                    end
                end else begin
                    chk({tag, ":w_closed"}, {bus.s_ready, bus.m_axi_wvalid}, 2'b00);
                end
                if (aw_pend) chk({tag, ":awvalid_held"}, bus.m_axi_awvalid, 1);
                if (bus.m_axi_awvalid) begin
                    chk({tag, ":awaddr"}, bus.m_axi_awaddr, exp_aa);
                    chk({tag, ":awlen"}, bus.m_axi_awlen, exp_len - 1);
                    if (bus.m_axi_awready) begin
                        chk({tag, ":awsize"}, bus.m_axi_awsize, 3'd2);
                        chk({tag, ":awburst"}, bus.m_axi_awburst, 2'b01);
                        in_data = 1;
                        bbeat = 0;
                        awwait = 0;
                        aw_pend = 0;
                    end else begin
                        awwait++;
                        aw_pend = 1;
                    end
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        idle_inputs();
        chk({tag, ":beats_total"}, sent, el0 + ((nb > 1) ? el1 : 0));
        $display("xfer %s addr=0x%0h len=%0d bursts=%0d beats=%0d cycles=%0d",
                 tag, a, n, burst, sent, cyc);
    endtask

    initial begin
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst:busy", busy, 0);
        chk("rst:done", done, 0);
        chk("rst:error", error, 0);
        chk("rst:awvalid", bus.m_axi_awvalid, 0);
        chk("rst:wvalid", bus.m_axi_wvalid, 0);
        chk("rst:bready", bus.m_axi_bready, 0);
        chk("rst:s_ready", bus.s_ready, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_xfer("single", 32'h100, 16'd1, 1, 32'h100, 1, 32'h0, 0, 2'b00, 0, 0, 0);
        run_xfer("split300", 32'h0, 16'd300, 2, 32'h0, 256, 32'h400, 44, 2'b00, 0, 0, 0);
        run_xfer("cross4k", 32'hFF8, 16'd4, 2, 32'hFF8, 2, 32'h1000, 2, 2'b00, 1, 1, 0);

        run_xfer("slverr", 32'hFF8, 16'd4, ERR_NB, 32'hFF8, 2, 32'h1000, 2, 2'b10, 0, 0, 1);
        bus.s_valid = 1'b1;
        bus.m_axi_wready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("slverr:error_hold", error, 1);
            chk("slverr:s_ready_idle", bus.s_ready, 0);
            chk("slverr:aw_idle", bus.m_axi_awvalid, 0);
        end
        idle_inputs();
        run_xfer("after_err", 32'h100, 16'd1, 1, 32'h100, 1, 32'h0, 0, 2'b00, 0, 0, 0);

        start = 1'b1; addr = 32'h200; length = 16'd0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("len0:done", done, 1);
        chk("len0:busy", busy, 0);
        chk("len0:awvalid", bus.m_axi_awvalid, 0);
        @(posedge clk); #1;
        chk("len0:done_clear", done, 0);
        chk("len0:awvalid_later", bus.m_axi_awvalid, 0);
        $display("xfer len0 addr=0x200 len=0");

        start = 1'b1; addr = 32'h40; length = 16'd8;
        @(posedge clk); #1;
        start = 1'b0;
        bus.m_axi_awready = 1'b1;
        for (int i = 0; i < 10 && !bus.m_axi_awvalid; i++) begin
            @(posedge clk); #1;
        end
        chk("midrst:awvalid", bus.m_axi_awvalid, 1);
        @(posedge clk); #1;
        bus.m_axi_awready = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_wdata = 32'h1234_5678;
        bus.s_wstrb = 4'hF;
        bus.m_axi_wready = 1'b1;
        @(posedge clk); #1;
        chk("midrst:in_data", bus.s_ready, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst:busy", busy, 0);
        chk("midrst:done", done, 0);
        chk("midrst:error", error, 0);
        chk("midrst:awvalid", bus.m_axi_awvalid, 0);
        chk("midrst:wvalid", bus.m_axi_wvalid, 0);
        chk("midrst:bready", bus.m_axi_bready, 0);
        chk("midrst:s_ready", bus.s_ready, 0);
        rst = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        $display("xfer midrst addr=0x40 len=8 aborted by reset");
        run_xfer("post_rst", 32'h40, 16'd3, 1, 32'h40, 3, 32'h0, 0, 2'b00, 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/iob2axi_wr_split.md
Name: iob2axi_wr_split

Overview:
- Native-to-AXI4 write bridge for long transfers.
- Accepts one transfer command (start address plus word count up to 2^XFER_W-1), then streams native write words into a sequence of AXI4 INCR bursts.
- Each burst is at most MAX_BURST beats and never crosses a 4 KB boundary.
- Sits between DMA/engine datapaths and the AXI interconnect; one burst outstanding at a time.

Parameters:
- ADDR_W, 32: native/AXI address width (bytes)
- DATA_W, 32: data width; power of two, 8..1024
- AXI_ID_W, 1: ID width
- AXI_LEN_W, 8: awlen width
- MAX_BURST, 256: max beats per burst; power of two, <= 2^AXI_LEN_W
- XFER_W, 16: transfer word-count width

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  command strobe, sampled only when busy=0
- addr  in  ADDR_W  transfer start byte address, DATA_W/8-aligned
- length  in  XFER_W  word count; 0 = no-op
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer end
- error  out  1  sticky error for current/last transfer
- s_valid  in  1  native write word valid
- s_wdata  in  DATA_W  write data
- s_wstrb  in  DATA_W/8  byte strobes
- s_ready  out  1  word accepted
- m_axi_awid  out  AXI_ID_W  constant 0
- m_axi_awaddr  out  ADDR_W  burst address
- m_axi_awlen  out  AXI_LEN_W  beats-1
- m_axi_awsize  out  3  log2(DATA_W/8)
- m_axi_awburst  out  2  constant 1 (INCR)
- m_axi_awlock / awcache / awprot / awqos  out  1/4/3/4  constants 0/2/2/0
- m_axi_awvalid  out  1; m_axi_awready  in  1
- m_axi_wdata  out  DATA_W; m_axi_wstrb  out  DATA_W/8; m_axi_wlast  out  1
- m_axi_wvalid  out  1; m_axi_wready  in  1
- m_axi_bid  in  AXI_ID_W; m_axi_bresp  in  2; m_axi_bvalid  in  1; m_axi_bready  out  1

Behaviour:
- Reset: rst asynchronous, active-high; clock clk. All registered state clears; busy=0, done=0, error=0, awvalid=0, wvalid=0, bready=0, s_ready=0, FSM=IDLE. Reset mid-transfer abandons the in-flight AXI transaction; the interconnect is reset by the same rst.
- FSM states IDLE, ADDR, DATA, RESP.
- IDLE: on start with length!=0, latch addr into cur_addr and length into remain, clear error, set busy, go to ADDR next cycle. Start with length=0 pulses done one cycle later without AXI activity. Start while busy is ignored.
- Burst size computation in ADDR: to4k = (4096 - cur_addr[11:0]) >> log2(DATA_W/8); blen = min(remain, MAX_BURST, to4k), registered. awlen = blen-1, awaddr = cur_addr.
- ADDR: awvalid=1 held stable until awready; on handshake go to DATA. W is never issued before AW is accepted.
- DATA: wvalid=s_valid; wdata/wstrb = s_wdata/s_wstrb combinationally; s_ready=wready. Beat counts on s_valid&wready. wlast=1 when beat==blen-1. On the last beat go to RESP.
- RESP: bready=1. On bvalid: error |= bresp[1]; remain -= blen; cur_addr += blen*(DATA_W/8) (wraps modulo 2^ADDR_W). Then if remain==0: done=1 for one cycle, busy=0, go to IDLE; else go to ADDR.
- Counter widths: beat counter AXI_LEN_W+1 bits; remain XFER_W bits; no overflow by construction.
- error holds its value until the next accepted start.

Optional Feature:
- Macro: IOB2AXI_WR_ABORT_EN.
- Defined: a burst response with bresp[1]=1 ends the transfer after that response. done pulses, busy drops, no further AW is issued, and s_ready stays 0 for the unsent words (the source must flush them).
- Undefined: all bursts complete regardless of response; error is sticky only.

Test Plan:
- addr=0x100, length=1 -> one AW: awaddr=0x100, awlen=0, awsize=2; one W beat with wlast=1; done one cycle after bvalid; error=0.
- addr=0, length=300, MAX_BURST=256 -> AW 0x000/awlen=255, then AW 0x400/awlen=43; wlast on beats 256 and 300.
- addr=0xFF8, length=4, DATA_W=32 -> AW 0xFF8/awlen=1, then AW 0x1000/awlen=1; data order preserved.
- wready toggling 1010..., s_valid gapped -> no beat lost or duplicated; awvalid held until awready; s_ready==wready in DATA.
- Two bursts, first bresp=2'b10 -> error=1. With IOB2AXI_WR_ABORT_EN: one AW only, done after first B. Without it: both bursts complete, error stays 1 until the next start.
- rst asserted mid-DATA -> next cycle all outputs at reset values; new start runs a clean transfer.
